// File: rtl/seg_bus_sequencer.sv
// Multi-byte memory operand sequencer: turns one 1/2/4-byte read or write at
// segment:offset into 8- or 16-bit bus beats and assembles a little-endian
// result. Offsets wrap inside the segment; physical addresses wrap at PHYS_W.
module seg_bus_sequencer #(
    parameter int BUS_W  = 8,
    parameter int PHYS_W = 20
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [1:0]           size,
    input  logic [15:0]          seg,
    input  logic [15:0]          off,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic                 done,
    output logic [PHYS_W-1:0]    address,
    output logic [BUS_W/8-1:0]   be,
    output logic [BUS_W-1:0]     out,
    input  logic [BUS_W-1:0]     data,
    output logic                 wren
);

    localparam int LANES = BUS_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_CAP   = 2'd2,
        WR       = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [15:0]         seg_q, seg_nxt;
    logic [15:0]         cur, cur_nxt;
    logic [2:0]          k, k_nxt;
    logic [2:0]          n, n_nxt;
    logic [31:0]         wdata_q, wdata_nxt;
    logic [31:0]         rdata_nxt;
    logic                busy_nxt, done_nxt, wren_nxt;
    logic [PHYS_W-1:0]   address_nxt;
    logic [LANES-1:0]    be_nxt;
    logic [BUS_W-1:0]    out_nxt;

    logic [2:0]          step;
    logic [15:0]         cur_adv;
    logic [2:0]          k_adv;
    logic [2:0]          n_new;

    // Real-mode physical address, truncated to the bus address width.
    function automatic logic [PHYS_W-1:0] phys(input logic [15:0] s, input logic [15:0] c);
        logic [31:0] sum;
        sum = {12'b0, s, 4'b0} + {16'b0, c};
        return sum[PHYS_W-1:0];
    endfunction

    // A beat is a full 16-bit word only when aligned and at least two bytes remain.
    function automatic logic beat_two(input logic [15:0] c, input logic [2:0] kk,
                                      input logic [2:0] nn);
        logic [2:0] rem;
        rem = nn - kk;
        return (LANES == 2) && !c[0] && (rem >= 3'd2);
    endfunction

    function automatic logic [LANES-1:0] beat_be(input logic [15:0] c, input logic [2:0] kk,
                                                 input logic [2:0] nn);
        logic [LANES-1:0] b;
        logic             two;
        two = beat_two(c, kk, nn);
        for (int l = 0; l < LANES; l++) begin
            b[l] = two || (LANES == 1) || (l[0] == c[0]);
        end
        return b;
    endfunction

    // Operand byte carried on lane l of the current beat.
    function automatic logic [2:0] lane_idx(input int l, input logic two, input logic [2:0] kk);
        return two ? kk + 3'(l) : kk;
    endfunction

    function automatic logic [BUS_W-1:0] beat_out(input logic [31:0] wd, input logic [15:0] c,
                                                  input logic [2:0] kk, input logic [2:0] nn);
        logic [BUS_W-1:0] o;
        logic [LANES-1:0] b;
        logic [31:0]      sh;
        logic             two;
        o   = '0;
        b   = beat_be(c, kk, nn);
        two = beat_two(c, kk, nn);
        for (int l = 0; l < LANES; l++) begin
            sh = wd >> {lane_idx(l, two, kk), 3'b000};
            if (b[l]) o[8*l +: 8] = sh[7:0];
        end
        return o;
    endfunction

    function automatic logic [31:0] beat_capture(input logic [BUS_W-1:0] d, input logic [15:0] c,
                                                 input logic [2:0] kk, input logic [2:0] nn);
        logic [31:0]      r;
        logic [LANES-1:0] b;
        logic             two;
        r   = '0;
        b   = beat_be(c, kk, nn);
        two = beat_two(c, kk, nn);
        for (int l = 0; l < LANES; l++) begin
            if (b[l]) r = r | ({24'b0, d[8*l +: 8]} << {lane_idx(l, two, kk), 3'b000});
        end
        return r;
    endfunction

    assign step    = beat_two(cur, k, n) ? 3'd2 : 3'd1;
    assign cur_adv = cur + {13'b0, step};
    assign k_adv   = k + step;
    assign n_new   = (size == 2'd0) ? 3'd1 : (size == 2'd1) ? 3'd2 : 3'd4;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt   = state;
        seg_nxt     = seg_q;
        cur_nxt     = cur;
        k_nxt       = k;
        n_nxt       = n;
        wdata_nxt   = wdata_q;
        rdata_nxt   = rdata;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        wren_nxt    = wren;
        address_nxt = address;
        be_nxt      = be;
        out_nxt     = out;
        case (state)
            IDLE: begin
                if (req) begin
                    seg_nxt     = seg;
                    cur_nxt     = off;
                    k_nxt       = 3'd0;
                    n_nxt       = n_new;
                    wdata_nxt   = wdata;
                    rdata_nxt   = '0;
                    busy_nxt    = 1'b1;
                    address_nxt = phys(seg, off);
                    be_nxt      = beat_be(off, 3'd0, n_new);
                    if (we) begin
                        state_nxt = WR;
                        out_nxt   = beat_out(wdata, off, 3'd0, n_new);
                        wren_nxt  = 1'b1;
                    end else begin
                        state_nxt = RD_ISSUE;
                        out_nxt   = '0;
                        wren_nxt  = 1'b0;
                    end
                end
            end
            RD_ISSUE: begin
                state_nxt = RD_CAP;
            end
            RD_CAP: begin
                rdata_nxt = rdata | beat_capture(data, cur, k, n);
                cur_nxt   = cur_adv;
                k_nxt     = k_adv;
                if (k_adv >= n) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    be_nxt    = '0;
                end else begin
                    state_nxt   = RD_ISSUE;
                    address_nxt = phys(seg_q, cur_adv);
                    be_nxt      = beat_be(cur_adv, k_adv, n);
                end
            end
            WR: begin
                cur_nxt = cur_adv;
                k_nxt   = k_adv;
                if (k_adv >= n) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    wren_nxt  = 1'b0;
                    be_nxt    = '0;
                    out_nxt   = '0;
                end else begin
                    address_nxt = phys(seg_q, cur_adv);
                    be_nxt      = beat_be(cur_adv, k_adv, n);
                    out_nxt     = beat_out(wdata_q, cur_adv, k_adv, n);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            seg_q   <= '0;
            cur     <= '0;
            k       <= '0;
            n       <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wren    <= 1'b0;
            address <= '0;
            be      <= '0;
            out     <= '0;
        end else begin
            state   <= state_nxt;
            seg_q   <= seg_nxt;
            cur     <= cur_nxt;
            k       <= k_nxt;
            n       <= n_nxt;
            wdata_q <= wdata_nxt;
            rdata   <= rdata_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            wren    <= wren_nxt;
            address <= address_nxt;
            be      <= be_nxt;
            out     <= out_nxt;
        end
    end

endmodule
